// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared types and helpers for the SHA-256 message-schedule expander.
//   word_t          32-bit schedule / message word
//   sched_state_t   IDLE / LOAD / EXPAND
//   WINDOW_WORDS    depth of the sliding 16-word schedule window
//   small_sigma0/1  SHA-256 lower-case sigma functions
// -----------------------------------------------------------------------------
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2
  } sched_state_t;

  localparam int WINDOW_WORDS = 16;

  // Fixed rotate/shift helpers, written as wiring so they cost no logic.
  function automatic word_t rotr7(input word_t x);
    return {x[6:0], x[31:7]};
  endfunction

  function automatic word_t rotr18(input word_t x);
    return {x[17:0], x[31:18]};
  endfunction

  function automatic word_t shr3(input word_t x);
    return {3'b000, x[31:3]};
  endfunction

  function automatic word_t rotr17(input word_t x);
    return {x[16:0], x[31:17]};
  endfunction

  function automatic word_t rotr19(input word_t x);
    return {x[18:0], x[31:19]};
  endfunction

  function automatic word_t shr10(input word_t x);
    return {10'b0, x[31:10]};
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr7(x) ^ rotr18(x) ^ shr3(x);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr17(x) ^ rotr19(x) ^ shr10(x);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// -----------------------------------------------------------------------------
// sha256_msg_schedule_if
// Bus bundle for the message-schedule expander.
// Handshake rule for both channels: a word moves on a rising clock edge where
// valid && ready are both high; the producer holds valid and data stable until
// that edge, and the consumer may change ready freely.
//   in_valid/in_ready/in_word             upstream message words M[t]
//   out_valid/out_ready/out_word/out_idx  downstream schedule words W[t]
//   busy                                  high while in LOAD or EXPAND
//   state                                 FSM state, for observation only
// Modports: slave = the expander, master = the environment driving it.
// -----------------------------------------------------------------------------
interface sha256_msg_schedule_if;
  import sha256_pkg::*;

  logic         in_valid;
  logic         in_ready;
  word_t        in_word;
  logic         out_valid;
  logic         out_ready;
  word_t        out_word;
  logic [5:0]   out_idx;
  logic         busy;
  sched_state_t state;

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_word, out_idx, busy, state
  );

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_word, out_idx, busy, state
  );

endinterface

// File: rtl/sha256_sched_word.sv
// -----------------------------------------------------------------------------
// sha256_sched_word
// Combinational SHA-256 schedule recurrence:
//   next_word = sigma1(w14) + w9 + sigma0(w1) + w0   (mod 2^32)
// Ports: w0, w1, w9, w14 (word_t in), next_word (word_t out).
// -----------------------------------------------------------------------------
module sha256_sched_word
  import sha256_pkg::*;
(
  input  word_t w0,
  input  word_t w1,
  input  word_t w9,
  input  word_t w14,
  output word_t next_word
);

  assign next_word = small_sigma1(w14) + w9 + small_sigma0(w1) + w0;

endmodule

// File: rtl/sha256_msg_schedule.sv
// -----------------------------------------------------------------------------
// sha256_msg_schedule
// Loads one 512-bit block as 16 words, then streams W[0..ROUNDS-1], one word
// per output handshake, from a 16-word sliding window.
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   bus    sha256_msg_schedule_if.slave (in_*, out_*, busy, state)
//   abort  only when SHA256_SCHED_ABORT_EN is defined: returns to IDLE
// Parameter: ROUNDS (16..64) schedule words emitted per block.
// -----------------------------------------------------------------------------
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  sha256_msg_schedule_if.slave        bus
`ifdef SHA256_SCHED_ABORT_EN
  ,
  input  logic                        abort
`endif
);

  sched_state_t state;
  logic [5:0]   cnt;
  word_t        window [WINDOW_WORDS];
  word_t        next_word;
  logic         in_fire;
  logic         out_fire;
  logic         last_round;
  logic         abort_now;

`ifdef SHA256_SCHED_ABORT_EN
  assign abort_now = abort;
`else
  assign abort_now = 1'b0;
`endif

  // Window[0] is always W[t]; window[1], [9], [14] feed W[t+16].
  sha256_sched_word u_sched_word (
    .w0        (window[0]),
    .w1        (window[1]),
    .w9        (window[9]),
    .w14       (window[14]),
    .next_word (next_word)
  );

  assign in_fire    = bus.in_valid && bus.in_ready;
  assign out_fire   = bus.out_valid && bus.out_ready;
  assign last_round = (cnt == 6'(ROUNDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      for (int i = 0; i < WINDOW_WORDS; i++) window[i] <= '0;
    end else if (abort_now) begin
      // Any simultaneous transfer is dropped; window contents are left stale.
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            window[0] <= bus.in_word;
            cnt       <= 6'd1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (in_fire) begin
            window[cnt[3:0]] <= bus.in_word;
            if (cnt == 6'd15) begin
              cnt   <= '0;
              state <= EXPAND;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        EXPAND: begin
          if (out_fire) begin
            for (int i = 0; i < WINDOW_WORDS - 1; i++) window[i] <= window[i + 1];
            window[WINDOW_WORDS - 1] <= next_word;
            if (last_round) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Outputs decode registered state only; in_ready is also held low during reset.
  assign bus.in_ready  = !rst && (state != EXPAND);
  assign bus.out_valid = (state == EXPAND);
  assign bus.out_word  = (state == EXPAND) ? window[0] : '0;
  assign bus.out_idx   = (state == EXPAND) ? cnt : '0;
  assign bus.busy      = (state != IDLE);
  assign bus.state     = state;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// -----------------------------------------------------------------------------
// tb_sha256_msg_schedule
// Self-checking bench for sha256_msg_schedule (ROUNDS=64). A reference
// schedule computed in the bench is queued per block and compared against
// every cycle out_valid is high; a table of known SHA-256 vectors is checked
// against captured outputs. Define SHA256_SCHED_ABORT_EN to exercise abort.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sha256_msg_schedule;

  typedef logic [31:0] blk_t [16];

  typedef struct {
    int          blk_sel;  // 0 = "abc" block, 1 = all-zero block
    int          idx;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef SHA256_SCHED_ABORT_EN
  logic abort = 1'b0;
`endif

  sha256_msg_schedule_if bus ();

  sha256_msg_schedule #(.ROUNDS(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SHA256_SCHED_ABORT_EN
    ,
    .abort (abort)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [37:0] exp_q[$];
  logic [31:0] got [64];
  int          out_count = 0;
  int          cyc = 0;
  int          out63_cyc = 0;
  bit          wait_first_in = 1'b0;
  int          in_gap = -1;
  int          ready_mode = 0;
  blk_t        abc_blk;
  blk_t        zero_blk;
  vec_t        vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  // Reference schedule, computed the textbook way over a flat W[0..63] array.
  task automatic push_expected(input blk_t m);
    logic [31:0] w [64];
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++)
      w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) exp_q.push_back({6'(t), w[t]});
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [31:0] w);
    int b;
    b = 0;
    bus.in_valid = 1'b1;
    bus.in_word  = w;
    @(negedge clk);
    while (!bus.in_ready && b < 300) begin
      b++;
      @(negedge clk);
    end
    if (b >= 300) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input blk_t m, input bit gaps, input bit hold);
    for (int i = 0; i < 16; i++) begin
      if (gaps && (i % 3 == 2)) begin
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_word(m[i]);
    end
    push_expected(m);
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic start_run();
    out_count = 0;
    for (int i = 0; i < 64; i++) got[i] = 32'hDEADBEEF;
  endtask

  task automatic wait_outputs(input int n, input string name);
    int b;
    b = 0;
    while (out_count < n && b < 3000) begin
      @(posedge clk);
      #2;
      b++;
    end
    check(name, out_count, n);
  endtask

  task automatic check_table(input int sel);
    for (int i = 0; i < 10; i++)
      if (vecs[i].blk_sel == sel)
        check($sformatf("vec_idx%0d", vecs[i].idx), got[vecs[i].idx], vecs[i].exp);
  endtask

  task automatic check_block_end(input string name);
    // Called right after the last transfer was seen: next cycle is IDLE.
    @(negedge clk);
    check({name, "_in_ready_after"}, bus.in_ready, 1);
    check({name, "_busy_after"}, bus.busy, 0);
    repeat (4) @(posedge clk);
    #2;
    check({name, "_count_exact"}, out_count, 64);
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  // ---------------- main ----------------
  initial begin
    for (int i = 0; i < 16; i++) begin
      abc_blk[i]  = 32'h0;
      zero_blk[i] = 32'h0;
    end
    abc_blk[0]  = 32'h61626380;
    abc_blk[15] = 32'h00000018;

    vecs[0] = '{0, 0,  32'h61626380};
    vecs[1] = '{0, 1,  32'h00000000};
    vecs[2] = '{0, 15, 32'h00000018};
    vecs[3] = '{0, 16, 32'h61626380};
    vecs[4] = '{0, 17, 32'h000F0000};
    vecs[5] = '{0, 63, 32'h12B1EDEB};
    vecs[6] = '{1, 0,  32'h00000000};
    vecs[7] = '{1, 16, 32'h00000000};
    vecs[8] = '{1, 40, 32'h00000000};
    vecs[9] = '{1, 63, 32'h00000000};

    bus.in_valid  = 1'b0;
    bus.in_word   = 32'h0;
    bus.out_ready = 1'b0;

    fork
      // out_ready driver: steady high or toggling every cycle
      forever begin
        @(posedge clk);
        #1;
        if (ready_mode == 0) bus.out_ready = 1'b1;
        else bus.out_ready = ~bus.out_ready;
      end
      // monitor / scoreboard
      forever begin
        @(negedge clk);
        cyc++;
        if (!rst) begin
          if (bus.in_valid && bus.in_ready && wait_first_in) begin
            in_gap        = cyc - out63_cyc;
            wait_first_in = 1'b0;
          end
          if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
              check("out_unexpected", {bus.out_idx, bus.out_word}, 0);
            end else begin
              check("out_idx_word", {bus.out_idx, bus.out_word}, exp_q[0]);
              check("in_ready_in_expand", bus.in_ready, 0);
              if (bus.out_ready) begin
                got[bus.out_idx] = bus.out_word;
                out_count++;
                void'(exp_q.pop_front());
                if (bus.out_idx == 6'd63) begin
                  out63_cyc     = cyc;
                  wait_first_in = 1'b1;
                end
              end
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_word", bus.out_word, 0);
    check("rst_out_idx", bus.out_idx, 0);
    check("rst_busy", bus.busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("in_ready_after_release", bus.in_ready, 1);

    // Scenario 1: "abc" block, out_ready steady high
    start_run();
    send_block(abc_blk, 1'b0, 1'b0);
    wait_outputs(64, "abc_outputs");
    check_block_end("abc");
    check_table(0);

    // Scenario 2: all-zero block
    start_run();
    send_block(zero_blk, 1'b0, 1'b0);
    wait_outputs(64, "zero_outputs");
    check_block_end("zero");
    check_table(1);

    // Scenario 3: toggling out_ready and input gaps
    ready_mode = 1;
    start_run();
    send_block(abc_blk, 1'b1, 1'b0);
    wait_outputs(64, "stall_outputs");
    ready_mode = 0;
    check_block_end("stall");
    check_table(0);

    // Scenario 4: reset mid-EXPAND at idx 30, then a fresh block
    start_run();
    send_block(abc_blk, 1'b0, 1'b0);
    begin
      int b;
      b = 0;
      while (bus.out_idx != 6'd30 && b < 200) begin
        @(posedge clk);
        #2;
        b++;
      end
    end
    check("reach_idx30", bus.out_idx, 30);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_word", bus.out_word, 0);
    check("midrst_out_idx", bus.out_idx, 0);
    check("midrst_busy", bus.busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_in_ready_release", bus.in_ready, 1);
    start_run();
    send_block(abc_blk, 1'b0, 1'b0);
    wait_outputs(64, "after_rst_outputs");
    check_block_end("after_rst");
    check_table(0);

    // Scenario 5: back-to-back blocks with in_valid held high
    start_run();
    in_gap        = -1;
    wait_first_in = 1'b0;
    send_block(abc_blk, 1'b0, 1'b1);
    send_block(zero_blk, 1'b0, 1'b0);
    check("b2b_first_word_gap", in_gap, 1);
    wait_outputs(128, "b2b_outputs");
    check_table(1);

`ifdef SHA256_SCHED_ABORT_EN
    // Scenario 6: abort at LOAD cnt=7
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) send_word(32'hA5A50000 + 32'(i));
    check("abort_busy_before", bus.busy, 1);
    abort        = 1'b1;
    bus.in_word  = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("abort_busy_after", bus.busy, 0);
    check("abort_in_ready_after", bus.in_ready, 1);
    start_run();
    send_block(abc_blk, 1'b0, 1'b0);
    wait_outputs(64, "abort_abc_outputs");
    check_block_end("abort_abc");
    check_table(0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
- SHA-256 message-schedule expander that consumes the rotate helpers: ROTR17/ROTR19/SHR10 for sigma1 and ROTR7/ROTR18/SHR3 for sigma0.
- Accepts one 512-bit block as 16 sequential 32-bit words, then streams W[0..63] one word per handshake to the compression-round stage downstream.
- Sits between the block padder (upstream) and the round engine (downstream).

Parameters:
- ROUNDS, 64, number of schedule words emitted per block; legal range 16..64.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream word valid
- in_ready  output  1  block can accept a word
- in_word  input  32  message word M[t], big-endian word order
- out_valid  output  1  schedule word valid
- out_ready  input  1  downstream accepts word
- out_word  output  32  schedule word W[t]
- out_idx  output  6  round index t of out_word
- busy  output  1  high in LOAD or EXPAND

Behaviour:
- Handshakes: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- State machine:
  - IDLE: in_ready=1, out_valid=0. The first input transfer goes to LOAD with load count 1.
  - LOAD: in_ready=1, out_valid=0. Each input transfer writes window[cnt] and increments cnt. The transfer at cnt==15 goes to EXPAND with cnt=0.
  - EXPAND: in_ready=0, out_valid=1, out_word=window[0], out_idx=cnt. On each output transfer:
    - window shifts down one (window[i] <= window[i+1]).
    - window[15] <= sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0], computed mod 2^32.
    - cnt increments.
    - The transfer at cnt==ROUNDS-1 goes to IDLE.
- Sigma functions:
  - sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - Both are purely combinational, off window registers only; no extra pipeline stage.
- Latency:
  - out_valid rises the cycle after the 16th input transfer.
  - in_ready rises the cycle after the final output transfer.
  - Throughput: one word per cycle in both directions; minimum 16+ROUNDS cycles per block.
- Backpressure: while out_ready=0, out_word/out_idx/window hold stable and out_valid stays high.
- Input during EXPAND is never accepted (in_ready=0); upstream must hold.
- in_valid low mid-LOAD: cnt and window hold; there is no timeout.
- Words computed for t>=ROUNDS are discarded; no overflow of cnt (6 bits, max 63).
- Reset, including mid-LOAD or mid-EXPAND: state=IDLE, cnt=0, window all 0.
  - Outputs: in_ready=0 while rst is high, 1 in the first cycle after release.
  - out_valid=0, out_word=0, out_idx=0, busy=0.
  - A partial block is discarded.

Optional Feature:
- Macro SHA256_SCHED_ABORT_EN adds input port abort (1 bit).
- With the macro defined:
  - abort high at a clock edge forces state=IDLE and cnt=0 from any state.
  - abort takes priority over any simultaneous input or output transfer; that transfer is not counted.
  - Window contents become don't-care.
- Without the macro: no abort port; the only way to leave LOAD/EXPAND early is rst.

Decomposition:
- Package sha256_pkg holds:
  - typedef word_t (logic [31:0]).
  - enum sched_state_t {IDLE, LOAD, EXPAND}.
  - constant WINDOW_WORDS=16.
  - functions small_sigma0/small_sigma1 built from the fixed rotate/shift helpers.
- One natural sub-module: sha256_sched_word.
  - Combinational; inputs w0, w1, w9, w14; output next word.
  - Instantiated once, reusable by the round engine's own verification.

Test Plan:
- "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018) with out_ready=1 -> out_word at idx16=0x61626380, idx17=0x000F0000, idx63=0x12B1EDEB; exactly 64 outputs; in_ready high the cycle after idx63.
- All-zero block -> 64 outputs, all 0x00000000, out_idx 0..63 in order.
- "abc" block with out_ready toggled 1/0 every cycle and in_valid gaps every 3rd cycle during LOAD -> identical word sequence to scenario 1; out_word stable while stalled.
- Assert rst at idx 30 of EXPAND, then load the "abc" block -> outputs restart at idx0=0x61626380, and all values match scenario 1.
- Hold in_valid=1 continuously across two back-to-back blocks -> in_ready=0 throughout EXPAND; the second block's first word is accepted the cycle after the idx63 transfer.
- With SHA256_SCHED_ABORT_EN defined: pulse abort at LOAD cnt=7 -> busy=0 next cycle; a following full "abc" block reproduces scenario 1.
